hazard_controller: RTL and testbench

//  Pipeline hazard sequencer paired with the operand forwarding logic. Detects load-use hazards

---
 rtl/hazard_controller.sv | 186 ++++++++++++++++++
 tb/tb_hazard_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//   Pipeline hazard sequencer for the IF/ID/EX front end. It works with the
//   operand forwarding network and does three things:
//     - detects load-use hazards that forwarding cannot cover, and inserts
//       exactly one bubble for each one;
//     - holds the pipe while a multi-cycle EX op (mul/div) is running, with a
//       watchdog that forces a release if the op never completes;
//     - flushes IF-ID and ID-EX when EX resolves a taken branch or jump.
//   Stall and flush outputs are combinational and act in the same cycle.
//   mc_busy_o and mc_timeout_o are registered.
//
// Optional feature: define HAZARD_PERF_EN to add two performance counters,
//   perf_stall_cycles_o and perf_flushes_o.
//
// State table
//   state   | meaning
//   RUN     | normal flow: branch flush, mc start, or load-use bubble
//   MC_WAIT | pipe frozen until mc_done_i arrives or the watchdog expires
//
// Ports
//   clk, rst_n            core clock; asynchronous active-low reset
//   id_rs1/rs2_addr_i     source registers of the instruction in ID
//   id_uses_rs1/rs2_i     the instruction in ID reads rs1 / rs2
//   ex_mem_read_i         the instruction in EX is a load
//   ex_rd_addr_i          destination register of the instruction in EX
//   ex_mc_start_i         first EX cycle of a multi-cycle op
//   mc_done_i             multi-cycle result valid (1-cycle pulse)
//   ex_branch_taken_i     EX resolved a taken branch or jump
//   stall_if/id/ex_o      hold PC+IF-ID / ID-EX / EX-MEM
//   flush_id_o            clear IF-ID to NOP
//   flush_ex_o            clear ID-EX to NOP (bubble)
//   mc_busy_o             registered: FSM is in MC_WAIT
//   mc_timeout_o          registered 1-cycle pulse: watchdog expired
//   perf_stall_cycles_o   (HAZARD_PERF_EN) number of cycles with stall_if high
//   perf_flushes_o        (HAZARD_PERF_EN) number of cycles with flush_id high
// -----------------------------------------------------------------------------
module hazard_controller #(
    parameter int MC_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic        ex_mem_read_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_mc_start_i,
    input  logic        mc_done_i,
    input  logic        ex_branch_taken_i,
    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        stall_ex_o,
    output logic        flush_id_o,
    output logic        flush_ex_o,
    output logic        mc_busy_o,
`ifdef HAZARD_PERF_EN
    output logic        mc_timeout_o,
    output logic [31:0] perf_stall_cycles_o,
    output logic [31:0] perf_flushes_o
`else
    output logic        mc_timeout_o
`endif
);

    localparam int CNT_W = $clog2(MC_TIMEOUT + 1);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic               load_use;
    logic               stall_if_c, stall_id_c, stall_ex_c, flush_id_c, flush_ex_c;

    // An x0 destination is never a real hazard, because x0 is hard-wired to zero.
    assign load_use = ex_mem_read_i && (ex_rd_addr_i != 5'd0) &&
                      ((id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        stall_if_c = 1'b0;
        stall_id_c = 1'b0;
        stall_ex_c = 1'b0;
        flush_id_c = 1'b0;
        flush_ex_c = 1'b0;
        case (state_q)
            RUN: begin
                busy_d = 1'b0;
                if (ex_branch_taken_i) begin
                    // The wrong-path mc op or load is squashed, so it causes no stall.
                    flush_id_c = 1'b1;
                    flush_ex_c = 1'b1;
                end else if (ex_mc_start_i) begin
                    stall_if_c = 1'b1;
                    stall_id_c = 1'b1;
                    stall_ex_c = 1'b1;
                    // If the op finishes in its first cycle, the pipe is released
                    // next cycle without entering MC_WAIT.
                    if (!mc_done_i) begin
                        state_d = MC_WAIT;
                        cnt_d   = CNT_W'(MC_TIMEOUT - 1);
                        busy_d  = 1'b1;
                    end
                end else if (load_use) begin
                    stall_if_c = 1'b1;
                    stall_id_c = 1'b1;
                    flush_ex_c = 1'b1;
                end
            end
            MC_WAIT: begin
                // The pipe stays frozen in the mc_done cycle too. The stall is
                // released on the following cycle.
                stall_if_c = 1'b1;
                stall_id_c = 1'b1;
                stall_ex_c = 1'b1;
                if (mc_done_i) begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d   = RUN;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Gating with rst_n holds every combinational output low during reset.
    assign stall_if_o   = rst_n & stall_if_c;
    assign stall_id_o   = rst_n & stall_id_c;
    assign stall_ex_o   = rst_n & stall_ex_c;
    assign flush_id_o   = rst_n & flush_id_c;
    assign flush_ex_o   = rst_n & flush_ex_c;
    assign mc_busy_o    = busy_q;
    assign mc_timeout_o = timeout_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_if_o) perf_stall_q <= perf_stall_q + 32'd1;
            if (flush_id_o) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cycles_o = perf_stall_q;
    assign perf_flushes_o      = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, mr, st, dn, br;
    logic        s_if, s_id, s_ex, f_id, f_ex, busy, tmo;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall, perf_flush;
    int          exp_stall = 0;
    int          exp_flush = 0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_controller #(.MC_TIMEOUT(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_rs1_addr_i     (rs1),
        .id_rs2_addr_i     (rs2),
        .id_uses_rs1_i     (u1),
        .id_uses_rs2_i     (u2),
        .ex_mem_read_i     (mr),
        .ex_rd_addr_i      (rd),
        .ex_mc_start_i     (st),
        .mc_done_i         (dn),
        .ex_branch_taken_i (br),
        .stall_if_o        (s_if),
        .stall_id_o        (s_id),
        .stall_ex_o        (s_ex),
        .flush_id_o        (f_id),
        .flush_ex_o        (f_ex),
        .mc_busy_o         (busy),
`ifdef HAZARD_PERF_EN
        .mc_timeout_o        (tmo),
        .perf_stall_cycles_o (perf_stall),
        .perf_flushes_o      (perf_flush)
`else
        .mc_timeout_o      (tmo)
`endif
    );

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic uu1,
                         input logic uu2, input logic m, input logic [4:0] d,
                         input logic s, input logic dd, input logic b);
        rs1 = a1; rs2 = a2; u1 = uu1; u2 = uu2; mr = m; rd = d; st = s; dn = dd; br = b;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One cycle: sample the outputs at the negedge, then move to just after the next posedge.
    // exp bit order: {stall_if, stall_id, stall_ex, flush_id, flush_ex, mc_busy, mc_timeout}
    task automatic step(input string tag, input logic [6:0] exp);
        logic [6:0] got;
        @(negedge clk);
        got = {s_if, s_id, s_ex, f_id, f_ex, busy, tmo};
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
`ifdef HAZARD_PERF_EN
        if (rst_n) begin
            exp_stall += int'(exp[6]);
            exp_flush += int'(exp[3]);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
`ifdef HAZARD_PERF_EN
        exp_stall = 0;
        exp_flush = 0;
`endif
    endtask

    initial begin
        do_reset();
        // Inputs that would cause a load-use hazard, applied while in reset.
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        step("reset_outputs", 7'b0000000);
        rst_n = 1'b1;
        idle();
        step("idle", 7'b0000000);

        // load-use hazards
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        step("lu_rs1", 7'b1100100);
        idle();
        step("lu_after", 7'b0000000);
        drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step("lu_x0", 7'b0000000);
        drive(5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        step("lu_rs2_unused", 7'b0000000);
        drive(5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        step("lu_rs2", 7'b1100100);
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        step("no_load", 7'b0000000);

        // mc op: start at t0, done at t3
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step("mc_t0", 7'b1110000);
        idle();
        step("mc_t1", 7'b1110010);
        // branch and load-use inputs are ignored while the pipe is frozen
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
        step("mc_t2_frozen", 7'b1110010);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("mc_t3_done", 7'b1110010);
        idle();
        step("mc_t4_run", 7'b0000000);

        // watchdog: MC_TIMEOUT=4, mc_done never arrives
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step("to_t0", 7'b1110000);
        idle();
        for (int i = 1; i <= 4; i++) step($sformatf("to_t%0d", i), 7'b1110010);
        step("to_t5_pulse", 7'b0000001);
        step("to_t6", 7'b0000000);

        // branch outranks mc start and load-use
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        step("br_prio", 7'b0001100);
        idle();
        step("br_after", 7'b0000000);

        // mc start and mc done in the same cycle
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        step("mc_same_t0", 7'b1110000);
        idle();
        step("mc_same_t1", 7'b0000000);

        // mc done in the same cycle as cnt==0: no timeout
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step("edge_t0", 7'b1110000);
        idle();
        for (int i = 1; i <= 3; i++) step($sformatf("edge_t%0d", i), 7'b1110010);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("edge_t4_done", 7'b1110010);
        idle();
        step("edge_t5_no_to", 7'b0000000);

        // mc done in RUN is ignored
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("stray_done", 7'b0000000);
        idle();
        step("stray_after", 7'b0000000);

        // a load-use pending at MC_WAIT exit is handled in RUN on the next cycle
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step("pend_t0", 7'b1110000);
        drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0);
        step("pend_t1_done", 7'b1110010);
        drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        step("pend_t2_lu", 7'b1100100);
        idle();
        step("pend_t3", 7'b0000000);

        // reset asserted during MC_WAIT
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step("rst_t0", 7'b1110000);
        idle();
        step("rst_t1", 7'b1110010);
        do_reset();
        step("rst_t2_low", 7'b0000000);
        rst_n = 1'b1;
        step("rst_after", 7'b0000000);
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        step("rst_run_lu", 7'b1100100);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("rst_run_br", 7'b0001100);
        idle();
        step("final_idle", 7'b0000000);

`ifdef HAZARD_PERF_EN
        // since the last reset: 1 load-use stall, then 1 flush
        vectors++;
        assert (perf_stall === 32'(exp_stall)) else begin
            miscompares++;
            $error("FAIL perf_stall observed=%0d expected=%0d", perf_stall, exp_stall);
        end
        vectors++;
        assert (perf_flush === 32'(exp_flush)) else begin
            miscompares++;
            $error("FAIL perf_flush observed=%0d expected=%0d", perf_flush, exp_flush);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
